// File: rtl/lrf_frame_sequencer.sv
// LRF fusion stream sequencer: input handshake, pipeline step, group/frame counters, registered AXIS output.
// Optional saturating statistics outputs are enabled by defining LRF_FRAME_STATS_EN.
//   state | meaning
//   IDLE  | post-reset, config latched on exit
//   RUN   | accepting input beats of a group
//   DRAIN | pushing flush bubbles until the pipeline is empty
module lrf_frame_sequencer #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int MAX_FUSE_LOG2   = 4,
  parameter int PIPELINE_DELAY  = 21,
  parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT
) (
  input  logic                               s_axis_aclk,
  input  logic                               s_axis_areset,
  input  logic [$clog2(MAX_FUSE_LOG2+1)-1:0] cfg_fuse_log2,
  input  logic                               cfg_emit_all,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic                               s_axis_tlast,
  output logic                               dp_step,
  output logic                               dp_flush,
  output logic                               dp_first_frame,
  output logic                               dp_load_avg,
  output logic                               dp_add_sub,
  input  logic [DATA_WIDTH-1:0]              dp_out,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tuser,
`ifdef LRF_FRAME_STATS_EN
  output logic                               err_tlast,
  output logic [31:0]                        stat_frames_in,
  output logic [31:0]                        stat_groups_out,
  output logic [31:0]                        stat_stall_cycles
`else
  output logic                               err_tlast
`endif
);

  localparam int BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(MAX_FUSE_LOG2+1);
  localparam int FW    = (MAX_FUSE_LOG2 > 0) ? MAX_FUSE_LOG2 : 1;
  localparam int DW    = $clog2(PIPELINE_DELAY+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic [CW-1:0]         fuse_log2_q, fuse_log2_d;
  logic                  emit_all_q, emit_all_d;
  logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
  logic [2:0]            tag_q [PIPELINE_DELAY];
  logic [2:0]            tag_d [PIPELINE_DELAY];
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic                  m_tuser_q, m_tuser_d;
  logic                  err_tlast_q, err_tlast_d;

  logic                  out_ok;
  logic                  beat_last;
  logic                  frame_last;
  logic [FW-1:0]         last_frame;
  logic [CW-1:0]         fuse_sel;
  logic [2:0]            tag_in;
  logic [2:0]            tag_out;
  logic                  run;

  // Pixel data goes straight to the datapath; only the handshake is used here.
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;

  assign out_ok     = ~m_tvalid_q | m_axis_tready;
  assign beat_last  = (beat_cnt_q == BW'(BEATS-1));
  assign last_frame = ~({FW{1'b1}} << fuse_log2_q);
  assign frame_last = (frame_cnt_q == last_frame);
  assign fuse_sel   = (cfg_fuse_log2 > CW'(MAX_FUSE_LOG2)) ? CW'(MAX_FUSE_LOG2) : cfg_fuse_log2;
  assign run        = (state_q == S_RUN);
  assign tag_in     = {~dp_flush & (emit_all_q | frame_last), beat_last, (beat_cnt_q == '0)};
  assign tag_out    = tag_q[PIPELINE_DELAY-1];

  assign dp_first_frame = run & (frame_cnt_q == '0);
  assign dp_load_avg    = run & (frame_cnt_q == '0);
  assign dp_add_sub     = run & frame_cnt_q[0];

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign err_tlast     = err_tlast_q;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    fuse_log2_d   = fuse_log2_q;
    emit_all_d    = emit_all_q;
    drain_cnt_d   = drain_cnt_q;
    err_tlast_d   = err_tlast_q;
    s_axis_tready = 1'b0;
    dp_step       = 1'b0;
    dp_flush      = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d     = S_RUN;
        fuse_log2_d = fuse_sel;
        emit_all_d  = cfg_emit_all;
      end
      S_RUN: begin
        s_axis_tready = out_ok;
        dp_step       = s_axis_tvalid & out_ok;
        if (dp_step) begin
          if (s_axis_tlast != beat_last) err_tlast_d = 1'b1;
          // An early tlast resyncs; a missing one is treated as end of frame anyway.
          if (s_axis_tlast | beat_last) begin
            beat_cnt_d = '0;
            if (frame_last) begin
              frame_cnt_d = '0;
              drain_cnt_d = DW'(PIPELINE_DELAY-1);
              state_d     = S_DRAIN;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        dp_step  = out_ok;
        dp_flush = 1'b1;
        if (out_ok) begin
          if (drain_cnt_q == '0) begin
            state_d     = S_RUN;
            fuse_log2_d = fuse_sel;
            emit_all_d  = cfg_emit_all;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tag_d = tag_q;
    if (dp_step) begin
      tag_d[0] = tag_in;
      for (int i = 1; i < PIPELINE_DELAY; i++) tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    if (dp_step && tag_out[2]) begin
      m_tdata_d  = dp_out;
      m_tlast_d  = tag_out[1];
      m_tuser_d  = tag_out[0];
      m_tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      fuse_log2_q <= '0;
      emit_all_q  <= 1'b0;
      drain_cnt_q <= '0;
      for (int i = 0; i < PIPELINE_DELAY; i++) tag_q[i] <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
      err_tlast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      fuse_log2_q <= fuse_log2_d;
      emit_all_q  <= emit_all_d;
      drain_cnt_q <= drain_cnt_d;
      tag_q       <= tag_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tuser_q   <= m_tuser_d;
      err_tlast_q <= err_tlast_d;
    end
  end

`ifdef LRF_FRAME_STATS_EN
  logic [31:0] frames_in_q, frames_in_d;
  logic [31:0] groups_out_q, groups_out_d;
  logic [31:0] stall_cyc_q, stall_cyc_d;

  always_comb begin
    frames_in_d  = frames_in_q;
    groups_out_d = groups_out_q;
    stall_cyc_d  = stall_cyc_q;
    if (dp_step && !dp_flush && s_axis_tlast && (frames_in_q != '1)) frames_in_d = frames_in_q + 1'b1;
    if (m_tvalid_q && m_axis_tready && m_tlast_q && (groups_out_q != '1)) groups_out_d = groups_out_q + 1'b1;
    if (m_tvalid_q && !m_axis_tready && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + 1'b1;
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      frames_in_q  <= '0;
      groups_out_q <= '0;
      stall_cyc_q  <= '0;
    end else begin
      frames_in_q  <= frames_in_d;
      groups_out_q <= groups_out_d;
      stall_cyc_q  <= stall_cyc_d;
    end
  end

  assign stat_frames_in    = frames_in_q;
  assign stat_groups_out   = groups_out_q;
  assign stat_stall_cycles = stall_cyc_q;
`endif

endmodule

// File: tb/tb_lrf_frame_sequencer.sv
// Directed bench for lrf_frame_sequencer: 16x16 frame, one beat per row, three-step datapath model.
module tb_lrf_frame_sequencer;
  localparam int PPB = 16;
  localparam int DIM = 16;
  localparam int DLY = 3;
  localparam int DW  = 8*PPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    cfg_fuse_log2 = 3'd2;
  logic          cfg_emit_all = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic          dp_step, dp_flush, dp_first_frame, dp_load_avg, dp_add_sub;
  logic [DW-1:0] dp_out;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tuser, err_tlast;
  logic          m_tready = 1'b1;
  logic          tog = 1'b0;

  int vec_cnt = 0;
  int mis_cnt = 0;

  logic [DW-1:0] pipe [DLY];
  logic [DW-1:0] out_d [$];
  logic          out_l [$];
  logic          out_u [$];
  logic          as_q [$];
  logic          ff_q [$];
  logic          la_q [$];
  int            flush_cnt = 0;
  int            stab_err = 0;
  int            ok_err = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;
  logic          prev_u = 1'b0;

  lrf_frame_sequencer #(
    .PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .MAX_FUSE_LOG2(4), .PIPELINE_DELAY(DLY), .DATA_WIDTH(DW)
  ) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .cfg_fuse_log2(cfg_fuse_log2), .cfg_emit_all(cfg_emit_all),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .dp_step(dp_step), .dp_flush(dp_flush), .dp_first_frame(dp_first_frame),
    .dp_load_avg(dp_load_avg), .dp_add_sub(dp_add_sub), .dp_out(dp_out),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: passes the input beat through DLY steps; bubbles carry a marker.
  always @(posedge clk) begin
    if (dp_step) begin
      pipe[0] <= dp_flush ? DW'(32'hBAD0BAD0) : s_tdata;
      for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign dp_out = pipe[DLY-1];

  always @(posedge clk) begin
    #1;
    m_tready = tog ? ~m_tready : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        out_d.push_back(m_tdata);
        out_l.push_back(m_tlast);
        out_u.push_back(m_tuser);
      end
      if (dp_step && dp_flush) flush_cnt++;
      if (dp_step && !dp_flush) begin
        as_q.push_back(dp_add_sub);
        ff_q.push_back(dp_first_frame);
        la_q.push_back(dp_load_avg);
      end
      if (stall_prev && (!m_tvalid || m_tdata != prev_d || m_tlast != prev_l || m_tuser != prev_u)) stab_err++;
      if (s_tvalid && !dp_flush && (s_tready != (!m_tvalid || m_tready))) ok_err++;
    end
    stall_prev = m_tvalid && !m_tready;
    prev_d = m_tdata;
    prev_l = m_tlast;
    prev_u = m_tuser;
  end

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int g, input int f, input int b);
    return (DW'(g) << 16) | (DW'(f) << 8) | DW'(b);
  endfunction

  task automatic drive_beat(input logic [DW-1:0] d, input logic l);
    int n;
    n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("tready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_beats(input int g, input int f, input int b0, input int b1, input logic tl);
    for (int b = b0; b <= b1; b++) drive_beat(pix(g, f, b), tl && (b == b1));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int base, input int n,
                            input int g0, input int f0, input int g1, input int f1, input bit seq);
    int got, de, ue, le, g, f;
    got = out_d.size() - base;
    de = 0; ue = 0; le = 0;
    chk({tag, "_count"}, got, n);
    for (int i = 0; i < got && i < n; i++) begin
      g = g0;
      f = f0;
      if (seq) f = i / 16;
      else if (i >= 16) begin
        g = g1;
        f = f1;
      end
      if (out_d[base+i] !== pix(g, f, i % 16)) de++;
      if (out_u[base+i] !== ((i % 16) == 0)) ue++;
      if (out_l[base+i] !== ((i % 16) == 15)) le++;
    end
    chk({tag, "_data_errs"}, de, 0);
    chk({tag, "_tuser_errs"}, ue, 0);
    chk({tag, "_tlast_errs"}, le, 0);
  endtask

  initial begin
    int ob, ab, fb;

    wait_cyc(3);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_dp_step", dp_step, 0);
    chk("rst_dp_first", dp_first_frame, 0);
    chk("rst_err", err_tlast, 0);
    rst = 1'b0;
    wait_cyc(3);
    chk("run_s_tready", s_tready, 1);

    // 4-frame group, only the fused frame is emitted
    ob = out_d.size(); ab = as_q.size(); fb = flush_cnt;
    for (int f = 0; f < 4; f++) send_beats(1, f, 0, 15, 1'b1);
    cfg_emit_all = 1'b1;
    wait_cyc(12);
    check_outs("t1", ob, 16, 1, 3, 0, 0, 1'b0);
    chk("t1_flush_steps", flush_cnt - fb, 3);

    // same group with every partial frame emitted
    ob = out_d.size(); ab = as_q.size(); fb = flush_cnt;
    for (int f = 0; f < 4; f++) send_beats(2, f, 0, 15, 1'b1);
    cfg_fuse_log2 = 3'd1;
    wait_cyc(12);
    check_outs("t2", ob, 64, 2, 0, 0, 0, 1'b1);
    chk("t2_flush_steps", flush_cnt - fb, 3);
    if (as_q.size() - ab >= 64) begin
      chk("t2_add_sub_seq", {as_q[ab+48], as_q[ab+32], as_q[ab+16], as_q[ab]}, 4'b1010);
      chk("t2_first_seq", {ff_q[ab+48], ff_q[ab+32], ff_q[ab+16], ff_q[ab]}, 4'b0001);
      chk("t2_load_avg_seq", {la_q[ab+48], la_q[ab+32], la_q[ab+16], la_q[ab]}, 4'b0001);
    end else chk("t2_step_count", as_q.size() - ab, 64);

    // output backpressure toggling 1010
    tog = 1'b1;
    ob = out_d.size(); fb = flush_cnt;
    for (int f = 0; f < 2; f++) send_beats(3, f, 0, 15, 1'b1);
    cfg_fuse_log2 = 3'd2;
    cfg_emit_all  = 1'b0;
    wait_cyc(24);
    tog = 1'b0;
    wait_cyc(4);
    check_outs("t3", ob, 32, 3, 0, 0, 0, 1'b1);
    chk("t3_stable_errs", stab_err, 0);
    chk("t3_tready_errs", ok_err, 0);
    chk("t3_flush_steps", flush_cnt - fb, 3);
    chk("t3_err_clean", err_tlast, 0);

    // early tlast at beat 9 of frame 1
    ob = out_d.size(); ab = as_q.size();
    send_beats(4, 0, 0, 15, 1'b1);
    chk("t4_err_before", err_tlast, 0);
    send_beats(4, 1, 0, 9, 1'b1);
    chk("t4_err_set", err_tlast, 1);
    send_beats(4, 2, 0, 15, 1'b1);
    send_beats(4, 3, 0, 15, 1'b1);
    cfg_fuse_log2 = 3'd0;
    cfg_emit_all  = 1'b1;
    wait_cyc(12);
    chk("t4_err_sticky", err_tlast, 1);
    check_outs("t4", ob, 16, 4, 3, 0, 0, 1'b0);
    chk("t4_steps", as_q.size() - ab, 58);
    if (as_q.size() - ab >= 58) begin
      chk("t4_add_sub_f1", as_q[ab+25], 1);
      chk("t4_add_sub_f2", as_q[ab+26], 0);
      chk("t4_first_f2", ff_q[ab+26], 0);
      chk("t4_add_sub_f3", as_q[ab+42], 1);
    end

    // reset while draining a one-frame group
    send_beats(5, 0, 0, 15, 1'b1);
    chk("t5_in_drain", dp_flush, 1);
    cfg_fuse_log2 = 3'd0;
    cfg_emit_all  = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_m_tvalid", m_tvalid, 0);
    chk("t5_rst_m_tdata", m_tdata, 0);
    chk("t5_rst_dp_flush", dp_flush, 0);
    chk("t5_rst_dp_step", dp_step, 0);
    chk("t5_rst_err", err_tlast, 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);

    // group of 1, config changed mid-frame applies to the following group of 2
    ob = out_d.size(); ab = as_q.size(); fb = flush_cnt;
    send_beats(6, 0, 0, 0, 1'b0);
    cfg_fuse_log2 = 3'd1;
    send_beats(6, 0, 1, 15, 1'b1);
    send_beats(7, 0, 0, 15, 1'b1);
    send_beats(7, 1, 0, 15, 1'b1);
    wait_cyc(12);
    check_outs("t6", ob, 32, 6, 0, 7, 1, 1'b0);
    chk("t6_flush_steps", flush_cnt - fb, 6);
    if (ff_q.size() - ab >= 48) begin
      chk("t6_first_after_rst", ff_q[ab], 1);
      chk("t6_grp2_first", ff_q[ab+16], 1);
      chk("t6_grp2_f1_first", ff_q[ab+32], 0);
      chk("t6_grp2_f1_add", as_q[ab+32], 1);
    end else chk("t6_step_count", ff_q.size() - ab, 48);
    chk("t6_err_clean", err_tlast, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end
endmodule
